// File: rtl/mac_result_sequencer_if.sv
// Result-sequencer bus: issue tracking, completion notify, register-file read
// port and the CV-X-IF style result channel.
//   master: the surrounding MAC / core side (drives issue, done, rf data, ready)
//   slave : mac_result_sequencer
interface mac_result_sequencer_if #(
  parameter int unsigned ID_W = 3
);
  logic            issue_valid_i;
  logic [ID_W-1:0] issue_id_i;
  logic            issue_ready_o;
  logic            done_valid_i;
  logic [ID_W-1:0] done_id_i;
  logic [ID_W-1:0] id_out_o;
  logic [31:0]     data_i;
  logic [4:0]      rd_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [ID_W-1:0] result_id_o;
  logic [31:0]     result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;

  modport master (
    output issue_valid_i, issue_id_i, done_valid_i, done_id_i, data_i, rd_i, result_ready_i,
    input  issue_ready_o, id_out_o, result_valid_o, result_id_o, result_data_o, result_rd_o,
           result_we_o
  );

  modport slave (
    input  issue_valid_i, issue_id_i, done_valid_i, done_id_i, data_i, rd_i, result_ready_i,
    output issue_ready_o, id_out_o, result_valid_o, result_id_o, result_data_o, result_rd_o,
           result_we_o
  );
endinterface

// File: rtl/mac_result_sequencer.sv
// In-order result sequencer for the MAC coprocessor.
// Issued IDs are queued in program order; each completes out of order (done),
// and results are emitted strictly in issue order on the result channel.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   seq_io  mac_result_sequencer_if.slave: issue_*, done_*, id_out_o/data_i/rd_i
//           register-file read port, result_* valid/ready channel
// DEPTH must be a power of two, >= 2 and <= 2**ID_W.
module mac_result_sequencer #(
  parameter int unsigned ID_W  = 3,
  parameter int unsigned DEPTH = 4
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  mac_result_sequencer_if.slave       seq_io
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned NumIds = 2 ** ID_W;

  typedef enum logic [1:0] {StIdle, StWait, StPresent} state_e;

  // Order FIFO
  logic [ID_W-1:0] fifo_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;

  // Per-ID status
  logic [NumIds-1:0] pending_q, pending_d;
  logic [NumIds-1:0] done_q, done_d;

  // Result channel registers
  state_e          state_q;
  logic            result_valid_q;
  logic [ID_W-1:0] result_id_q;
  logic [31:0]     result_data_q;
  logic [4:0]      result_rd_q;

  logic            empty, full, push, pop;
  logic [ID_W-1:0] head_id;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign head_id = fifo_q[rptr_q];
  // Ready depends on the current count only; a same-cycle pop does not free a slot.
  assign push    = seq_io.issue_valid_i && !full;
  assign pop     = result_valid_q && seq_io.result_ready_i;

  assign seq_io.issue_ready_o  = !full;
  assign seq_io.id_out_o       = empty ? '0 : head_id;
  assign seq_io.result_valid_o = result_valid_q;
  assign seq_io.result_we_o    = result_valid_q;
  assign seq_io.result_id_o    = result_id_q;
  assign seq_io.result_data_o  = result_data_q;
  assign seq_io.result_rd_o    = result_rd_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Retire clears before issue sets, so re-issuing the retiring ID keeps it
  // pending with a fresh (cleared) done bit.
  always_comb begin
    pending_d = pending_q;
    done_d    = done_q;
    if (seq_io.done_valid_i && pending_q[seq_io.done_id_i]) begin
      done_d[seq_io.done_id_i] = 1'b1;
    end
    if (pop) begin
      pending_d[head_id] = 1'b0;
      done_d[head_id]    = 1'b0;
    end
    if (push) begin
      pending_d[seq_io.issue_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      done_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= seq_io.issue_id_i;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q   <= count_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // Capture uses the registered done bit only, so the register file write that
  // accompanied done_valid_i has landed before data_i is sampled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_data_q  <= '0;
      result_rd_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (done_q[head_id]) begin
            result_valid_q <= 1'b1;
            result_id_q    <= head_id;
            result_data_q  <= seq_io.data_i;
            result_rd_q    <= seq_io.rd_i;
            state_q        <= StPresent;
          end
        end
        StPresent: begin
          if (seq_io.result_ready_i) begin
            result_valid_q <= 1'b0;
            state_q        <= (count_d != '0) ? StWait : StIdle;
          end
        end
        default: begin
          state_q        <= StIdle;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Issuing an ID that is still outstanding is a protocol violation, unless
  // that ID retires in the same cycle.
  a_no_dup_issue : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (!pending_q[seq_io.issue_id_i] || (pop && (head_id == seq_io.issue_id_i))));

endmodule

// File: tb/tb_mac_result_sequencer.sv
module tb_mac_result_sequencer;

  logic clk;
  logic rst_n;

  mac_result_sequencer_if #(.ID_W(3)) bus ();

  mac_result_sequencer #(
    .ID_W (3),
    .DEPTH(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .seq_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model read by the head ID
  logic [31:0] rf_data [8];
  logic [4:0]  rf_rd   [8];
  always_comb begin
    bus.data_i = rf_data[bus.id_out_o];
    bus.rd_i   = rf_rd[bus.id_out_o];
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       iv;
    logic [2:0] iid;
    logic       dv;
    logic [2:0] did;
    logic       rr;
    logic       exp_ir;
    logic [2:0] exp_head;
    logic       exp_valid;
    logic [2:0] exp_id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input int iid, input logic dv, input int did,
                     input logic rr, input logic ir, input int head, input logic v,
                     input int id);
    vec_t t;
    t.iv = iv; t.iid = 3'(iid); t.dv = dv; t.did = 3'(did); t.rr = rr;
    t.exp_ir = ir; t.exp_head = 3'(head); t.exp_valid = v; t.exp_id = 3'(id);
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_none(input string name);
    chk({name, ".valid"}, 32'(bus.result_valid_o), 32'd0);
    chk({name, ".we"}, 32'(bus.result_we_o), 32'd0);
  endtask

  task automatic chk_res(input string name, input int id);
    chk({name, ".valid"}, 32'(bus.result_valid_o), 32'd1);
    chk({name, ".we"}, 32'(bus.result_we_o), 32'd1);
    chk({name, ".id"}, 32'(bus.result_id_o), 32'(id));
    chk({name, ".data"}, bus.result_data_o, rf_data[id]);
    chk({name, ".rd"}, 32'(bus.result_rd_o), 32'(rf_rd[id]));
  endtask

  task automatic set_in(input logic iv, input int iid, input logic dv, input int did,
                        input logic rr);
    bus.issue_valid_i  = iv;
    bus.issue_id_i     = 3'(iid);
    bus.done_valid_i   = dv;
    bus.done_id_i      = 3'(did);
    bus.result_ready_i = rr;
  endtask

  task automatic rf_default();
    for (int i = 0; i < 8; i++) begin
      rf_data[i] = 32'hC0DE_0000 | 32'(i * 32'h111);
      rf_rd[i]   = 5'(i + 10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rf_default();
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    // Reset state
    chk("rst.issue_ready", 32'(bus.issue_ready_o), 32'd1);
    chk("rst.id_out", 32'(bus.id_out_o), 32'd0);
    chk("rst.valid", 32'(bus.result_valid_o), 32'd0);
    chk("rst.we", 32'(bus.result_we_o), 32'd0);
    chk("rst.id", 32'(bus.result_id_o), 32'd0);
    chk("rst.data", bus.result_data_o, 32'd0);
    chk("rst.rd", 32'(bus.result_rd_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: done at t -> result at t+2
    set_in(1, 3, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk("t1.head", 32'(bus.id_out_o), 32'd3);
    rf_data[3] = 32'hDEAD_BEEF;
    rf_rd[3]   = 5'd5;
    set_in(0, 0, 1, 3, 0); tick();
    set_in(0, 0, 0, 0, 0);
    chk_none("t1.t+1");
    tick();
    chk_res("t1.t+2", 3);
    chk("t1.data_abs", bus.result_data_o, 32'hDEAD_BEEF);
    chk("t1.rd_abs", 32'(bus.result_rd_o), 32'd5);
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk_none("t1.pop");
    chk("t1.empty_head", 32'(bus.id_out_o), 32'd0);
    rf_default();

    // Table: in-order retire, full FIFO, non-pending done
    //   iv iid dv did rr | ir head v id
    add(1, 1, 0, 0, 0,   1, 1, 0, 0);
    add(1, 2, 0, 0, 0,   1, 1, 0, 0);
    add(1, 3, 0, 0, 0,   1, 1, 0, 0);
    add(0, 0, 1, 3, 0,   1, 1, 0, 0);
    add(0, 0, 1, 2, 0,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 0, 1, 1, 0,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0,   1, 1, 1, 1);
    add(0, 0, 0, 0, 1,   1, 2, 0, 0);
    add(0, 0, 0, 0, 0,   1, 2, 1, 2);
    add(0, 0, 0, 0, 1,   1, 3, 0, 0);
    add(0, 0, 0, 0, 0,   1, 3, 1, 3);
    add(0, 0, 0, 0, 1,   1, 0, 0, 0);
    add(1, 4, 0, 0, 0,   1, 4, 0, 0);
    add(1, 5, 0, 0, 0,   1, 4, 0, 0);
    add(1, 6, 0, 0, 0,   1, 4, 0, 0);
    add(1, 7, 0, 0, 0,   0, 4, 0, 0);
    add(1, 2, 1, 4, 0,   0, 4, 0, 0); // 5th issue dropped
    add(0, 0, 0, 0, 0,   0, 4, 1, 4);
    add(0, 0, 0, 0, 1,   1, 5, 0, 0);
    add(0, 0, 1, 5, 0,   1, 5, 0, 0);
    add(0, 0, 1, 6, 1,   1, 5, 1, 5);
    add(0, 0, 1, 7, 1,   1, 6, 0, 0);
    add(0, 0, 0, 0, 1,   1, 6, 1, 6);
    add(0, 0, 0, 0, 1,   1, 7, 0, 0);
    add(0, 0, 0, 0, 1,   1, 7, 1, 7);
    add(0, 0, 0, 0, 1,   1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   1, 0, 0, 0); // dropped id2 never entered
    add(0, 0, 1, 6, 0,   1, 0, 0, 0); // done for non-pending id6
    add(1, 6, 0, 0, 0,   1, 6, 0, 0);
    add(0, 0, 0, 0, 0,   1, 6, 0, 0);
    add(0, 0, 0, 0, 0,   1, 6, 0, 0);
    add(0, 0, 0, 0, 0,   1, 6, 0, 0);
    add(1'b0, 0, 1, 6, 0, 1, 6, 0, 0);
    add(0, 0, 0, 0, 0,   1, 6, 1, 6);
    add(0, 0, 0, 0, 1,   1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      set_in(vecs[i].iv, int'(vecs[i].iid), vecs[i].dv, int'(vecs[i].did), vecs[i].rr);
      tick();
      chk({nm, ".issue_ready"}, 32'(bus.issue_ready_o), 32'(vecs[i].exp_ir));
      chk({nm, ".head"}, 32'(bus.id_out_o), 32'(vecs[i].exp_head));
      if (vecs[i].exp_valid) chk_res(nm, int'(vecs[i].exp_id));
      else chk_none(nm);
    end
    set_in(0, 0, 0, 0, 0);

    // 4: back-pressure holds the result stable
    set_in(1, 1, 0, 0, 0); tick();
    set_in(1, 2, 0, 0, 0); tick();
    set_in(0, 0, 1, 1, 0); tick();
    set_in(0, 0, 1, 2, 0); tick();
    set_in(0, 0, 0, 0, 0);
    chk_res("t4.present", 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_res($sformatf("t4.hold%0d", i), 1);
      chk($sformatf("t4.hold%0d.head", i), 32'(bus.id_out_o), 32'd1);
    end
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk_none("t4.pop");
    chk("t4.pop.head", 32'(bus.id_out_o), 32'd2);
    tick();
    chk_res("t4.next", 2);
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk_none("t4.drain");

    // 5: issue while full during handshake, then issue+pop at count 3
    for (int i = 0; i < 4; i++) begin
      set_in(1, i, 0, 0, 0); tick();
    end
    set_in(0, 0, 0, 0, 0);
    chk("t5.full", 32'(bus.issue_ready_o), 32'd0);
    set_in(0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_res("t5.r0", 0);
    set_in(1, 4, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk("t5.cnt3.ready", 32'(bus.issue_ready_o), 32'd1);
    chk("t5.cnt3.head", 32'(bus.id_out_o), 32'd1);
    chk_none("t5.pop0");
    set_in(0, 0, 1, 1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_res("t5.r1", 1);
    set_in(1, 1, 0, 0, 1); tick(); // re-issue id1 while it retires
    set_in(0, 0, 0, 0, 0);
    chk("t5.swap.ready", 32'(bus.issue_ready_o), 32'd1);
    chk("t5.swap.head", 32'(bus.id_out_o), 32'd2);
    set_in(1, 5, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    chk("t5.refull", 32'(bus.issue_ready_o), 32'd0);
    set_in(0, 0, 1, 2, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_res("t5.r2", 2);
    set_in(0, 0, 1, 3, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk("t5.head3", 32'(bus.id_out_o), 32'd3);
    tick();
    chk_res("t5.r3", 3);
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk("t5.head1", 32'(bus.id_out_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_none($sformatf("t5.fresh%0d", i));
    end
    set_in(0, 0, 1, 1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_res("t5.r1b", 1);
    set_in(0, 0, 1, 5, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk("t5.head5", 32'(bus.id_out_o), 32'd5);
    tick();
    chk_res("t5.r5", 5);
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk("t5.empty", 32'(bus.id_out_o), 32'd0);
    chk_none("t5.end");

    // 6: reset while presenting drops the result at once
    set_in(1, 2, 0, 0, 0); tick();
    set_in(0, 0, 1, 2, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_res("t6.present", 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_none("t6.rst");
    chk("t6.rst.ready", 32'(bus.issue_ready_o), 32'd1);
    chk("t6.rst.head", 32'(bus.id_out_o), 32'd0);
    chk("t6.rst.id", 32'(bus.result_id_o), 32'd0);
    chk("t6.rst.data", bus.result_data_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_none("t6.after");
    chk("t6.after.head", 32'(bus.id_out_o), 32'd0);
    set_in(1, 2, 0, 0, 0); tick();
    set_in(0, 0, 1, 2, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_res("t6.recover", 2);
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
    chk_none("t6.final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
